// File: rtl/division.sv
// Sequential restoring integer divider for the MIPS datapath (DIV / DIVU).
// Works on operand magnitudes and produces one quotient bit per clock. The
// signs are applied in a single fix-up cycle at the end. The quotient is
// meant for LO and the remainder for HI.
module division #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic             isSigned,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             endSignal,
    output logic             divZero,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WORK = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's complement negation when neg is set. The most negative value
    // maps onto itself, and that result is read as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        cond_neg = neg ? (-v) : v;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] rem_r;        // partial remainder, always < divisor magnitude
    logic [WIDTH-1:0] dvd_r;        // dividend shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_r;        // divisor magnitude
    logic [CW-1:0]    cnt_r;
    logic             negq_r;
    logic             negr_r;
    logic             dz_r;         // divisor was zero for the current operation
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             endsignal_r;
    logic             divzero_r;
    logic             busy_r;

    logic             div_zero_s;
    logic [WIDTH:0]   rem_shift_s;  // WIDTH+1 bit partial remainder after the shift
    logic             trial_ok_s;
    logic [WIDTH-1:0] trial_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] dvd_next_s;

    assign div_zero_s = (divisor == {WIDTH{1'b0}});

    // One restoring step: shift, trial subtract, keep or restore.
    always_comb begin
        rem_shift_s = {rem_r, dvd_r[WIDTH-1]};
        trial_ok_s  = (rem_shift_s >= {1'b0, dvs_r});
        // The difference is below the divisor, so the low WIDTH bits hold all of it.
        trial_s     = rem_shift_s[WIDTH-1:0] - dvs_r;
        if (trial_ok_s) begin
            rem_next_s = trial_s;
            dvd_next_s = {dvd_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = rem_shift_s[WIDTH-1:0];
            dvd_next_s = {dvd_r[WIDTH-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = div_zero_s ? FIX : WORK;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WORK: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = WORK;
                end
            end
            FIX:     state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            rem_r       <= {WIDTH{1'b0}};
            dvd_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            cnt_r       <= CNT_ZERO;
            negq_r      <= 1'b0;
            negr_r      <= 1'b0;
            dz_r        <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            endsignal_r <= 1'b0;
            divzero_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        // A zero divisor keeps the raw dividend, which is returned as the remainder.
                        dvd_r     <= div_zero_s ? dividend
                                                : cond_neg(isSigned & dividend[WIDTH-1], dividend);
                        dvs_r     <= cond_neg(isSigned & divisor[WIDTH-1], divisor);
                        negq_r    <= isSigned & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        negr_r    <= isSigned & dividend[WIDTH-1];
                        dz_r      <= div_zero_s;
                        rem_r     <= {WIDTH{1'b0}};
                        cnt_r     <= CNT_ZERO;
                        busy_r    <= 1'b1;
                        divzero_r <= 1'b0;
                    end
                end
                WORK: begin
                    rem_r <= rem_next_s;
                    dvd_r <= dvd_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                end
                FIX: begin
                    if (dz_r) begin
                        quotient_r  <= {WIDTH{1'b1}};
                        remainder_r <= dvd_r;
                        divzero_r   <= 1'b1;
                    end else begin
                        quotient_r  <= cond_neg(negq_r, dvd_r);
                        remainder_r <= cond_neg(negr_r, rem_r);
                    end
                    endsignal_r <= 1'b1;
                end
                DONE: begin
                    endsignal_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
                default: begin
                    endsignal_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign endSignal = endsignal_r;
    assign divZero   = divzero_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_division.sv
// Self-checking bench for the division block: directed cases plus random
// operands compared against a plain-arithmetic reference model.
module tb_division;

    logic        Clk;
    logic        reset;
    logic        start;
    logic        isSigned;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        endSignal;
    logic        divZero;
    logic        busy;

    int checks_cnt;
    int errors_cnt;

    division #(.WIDTH(32)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .start     (start),
        .isSigned  (isSigned),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .endSignal (endSignal),
        .divZero   (divZero),
        .busy      (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS semantics from C-style truncating arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa;
        longint sb;
        dz = (b == 32'd0);
        if (dz) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // One division. restart_edge > 0 pulses start (with junk operands) while busy;
    // done_start holds start high during the DONE cycle, which must be ignored.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input int restart_edge, input bit done_start);
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        int          edges;
        model(a, b, s, eq, er, edz);
        @(negedge Clk);
        dividend = a;
        divisor  = b;
        isSigned = s;
        start    = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        edges = 1;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        while (!endSignal && edges < 100) begin
            if (edges == restart_edge) begin
                start    = 1'b1;
                dividend = 32'h1234_5678;
                divisor  = 32'd3;
                isSigned = ~s;
            end else begin
                start = 1'b0;
            end
            @(negedge Clk);
            edges++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(edges), edz ? 32'd2 : 32'd34);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " divZero"}, 32'(divZero), 32'(edz));
        if (done_start) begin
            start    = 1'b1;
            dividend = 32'd50;
            divisor  = 32'd5;
        end
        @(negedge Clk);
        start = 1'b0;
        check({tag, " end_pulse_low"}, 32'(endSignal), 32'd0);
        check({tag, " busy_low"}, 32'(busy), 32'd0);
        if (done_start) begin
            @(negedge Clk);
            check({tag, " done_start_ignored"}, 32'(busy), 32'd0);
            check({tag, " result_held"}, quotient, eq);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          sel;
        int          saw_end;
        checks_cnt = 0;
        errors_cnt = 0;
        reset    = 1'b1;
        start    = 1'b0;
        isSigned = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (2) @(negedge Clk);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset endSignal", 32'(endSignal), 32'd0);
        check("reset divZero", 32'(divZero), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;

        run_div("divu_7_2", 32'd7, 32'd2, 1'b0, 0, 1'b0);
        run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
        run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b0);
        run_div("divu_ff_2", 32'hFFFF_FFFF, 32'd2, 1'b0, 0, 1'b0);
        run_div("div_m1_2", 32'hFFFF_FFFF, 32'd2, 1'b1, 0, 1'b0);
        run_div("divzero_5", 32'd5, 32'd0, 1'b0, 0, 1'b0);
        run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
        run_div("divu_min", 32'h8000_0000, 32'd3, 1'b0, 0, 1'b0);
        run_div("div_min_3", 32'h8000_0000, 32'd3, 1'b1, 0, 1'b0);
        run_div("div_zero_dvd", 32'd0, 32'd9, 1'b1, 0, 1'b0);
        run_div("restart_100_7", 32'd100, 32'd7, 1'b0, 5, 1'b0);
        run_div("done_start", 32'd100, 32'd7, 1'b1, 0, 1'b1);
        check("divzero_cleared_by_start", 32'(divZero), 32'd0);

        // Asynchronous reset in the middle of a division.
        @(negedge Clk);
        dividend = 32'd1000;
        divisor  = 32'd7;
        isSigned = 1'b0;
        start    = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (9) @(negedge Clk);
        #2 reset = 1'b1;
        #1;
        check("async quotient", quotient, 32'd0);
        check("async remainder", remainder, 32'd0);
        check("async endSignal", 32'(endSignal), 32'd0);
        check("async divZero", 32'(divZero), 32'd0);
        check("async busy", 32'(busy), 32'd0);
        @(negedge Clk);
        reset   = 1'b0;
        saw_end = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (endSignal) saw_end++;
        end
        check("aborted_no_end", 32'(saw_end), 32'd0);
        run_div("after_reset_9_3", 32'd9, 32'd3, 1'b0, 0, 1'b0);

        // Randomised operands with corner values mixed in.
        for (int n = 0; n < 40; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            rs  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            case (sel)
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 16);
                2:       rb = -32'($urandom_range(1, 16));
                3:       ra = 32'h8000_0000;
                4:       rb = rb >> $urandom_range(1, 31);
                default: ra = ra;
            endcase
            run_div($sformatf("rand%0d", n), ra, rb, rs, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule

// File: doc/division.md
Name: division

Overview:
- Sequential restoring integer divider for the MIPS datapath; the inverse of the shift-add multiplier.
- Serves DIV/DIVU: quotient goes to LO, remainder to HI.
- Started by a one-cycle `start` pulse from the control FSM; produces one quotient bit per cycle; signals completion with a one-cycle `endSignal` pulse.

Parameters:
- WIDTH, 32, operand/result width in bits; counter width is clog2(WIDTH)+1.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  begin a division; sampled only in IDLE.
- isSigned  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- quotient  output  WIDTH  result for LO; holds until next completion.
- remainder  output  WIDTH  result for HI; holds until next completion.
- endSignal  output  1  one-cycle pulse when quotient/remainder are valid.
- divZero  output  1  set with endSignal when divisor was 0; holds until next start.
- busy  output  1  high from the edge after start until the edge that returns to IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, quotient=0, remainder=0, endSignal=0, divZero=0, busy=0, internal registers and counter=0.
  - Reset mid-operation aborts; no endSignal is produced.
- States: IDLE, WORK, FIX, DONE.
- IDLE, start=1 at edge E0:
  - Latch isSigned and operand magnitudes: when isSigned=1, negate negative operands; when isSigned=0, use raw values.
  - Record negQ = isSigned & (dividend[MSB]^divisor[MSB]) and negR = isSigned & dividend[MSB].
  - Clear partial remainder (WIDTH+1 bits) and counter; busy=1; divZero=0.
  - If divisor==0, go to FIX with the divZero flag. Otherwise go to WORK.
- WORK, edges E1..E32, one iteration per edge:
  - Shift {rem, dvd} left by 1.
  - trial = rem - dvs.
  - If trial is non-negative: rem=trial and shift in quotient bit 1; else shift in 0.
  - counter++. On the edge where counter reaches WIDTH-1→WIDTH, go to FIX.
- FIX, edge E33 (or E1 for divide-by-zero):
  - quotient = negQ ? -q : q; remainder = negR ? -r : r.
  - Divide-by-zero: quotient=all ones, remainder=dividend as latched (unmodified), divZero=1.
  - endSignal=1; go to DONE.
- DONE, next edge: endSignal=0, busy=0, go to IDLE.
- Latency:
  - Normal division: endSignal is high during the cycle after E33, i.e. 34 edges from start; 35 cycles until a new start is accepted.
  - Divide-by-zero: endSignal high after E1.
- Boundary conditions:
  - start while busy: ignored; operands not re-sampled.
  - start on the same edge DONE returns to IDLE: ignored; must be held or reissued once in IDLE.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. No flag; this falls out of the magnitude arithmetic with WIDTH-bit truncation.
  - Magnitude of 0x80000000 is taken as unsigned 0x80000000; the internal datapath must not sign-extend it.
  - Remainder sign equals dividend sign (MIPS/C truncation); |remainder| < |divisor|.
  - dividend=0: quotient=0, remainder=0 (via the normal path, full latency).
- Outputs are registered only. Nothing combinational from inputs reaches outputs.

Test Plan:
- DIVU 7/2: start=1, isSigned=0 -> endSignal pulse 34 edges later; quotient=0x00000003, remainder=0x00000001, divZero=0.
- DIV -7/2 (0xFFFFFFF9 / 0x00000002, isSigned=1) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also 7/-2 -> quotient=0xFFFFFFFD, remainder=0x00000001.
- DIVU 0xFFFFFFFF/0x00000002 -> quotient=0x7FFFFFFF, remainder=1. The same operands with isSigned=1 (-1/2) -> quotient=0, remainder=0xFFFFFFFF.
- Divide-by-zero 5/0 -> endSignal after 2nd edge; quotient=0xFFFFFFFF, remainder=0x00000005, divZero=1, busy low one edge later.
- Signed overflow 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. Also 100/7 with a second start pulse at edge E5 -> second start ignored; quotient=14, remainder=2.
- Reset asserted asynchronously at edge E10 of a division -> all outputs 0 immediately, no endSignal. A new DIVU 9/3 afterwards -> quotient=3, remainder=0 at normal latency.
